// File: rtl/alu_divider.sv
// alu_divider: multi-cycle radix-2 restoring divide/modulo unit for ALU
// opcodes DIVU/MODU/DIVS/MODS. Produces one quotient bit per clock;
// a result is ready WIDTH+1 clocks after start is accepted.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_MODU = 4'b1010;
  localparam logic [3:0] OP_DIVS = 4'b1011;
  localparam logic [3:0] OP_MODS = 4'b1100;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder (always < divisor)
  logic [WIDTH-1:0] dvd_q;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] aorig_q;    // original dividend, for the divide-by-zero MOD result
  logic             is_mod_q;
  logic             unsup_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] y_q;
  logic             dbz_q;

  logic             op_ok;
  logic             op_sgn;
  logic             op_mod;
  logic [WIDTH:0]   rem_sh;     // shifted remainder; the extra bit carries the compare
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] y_d;
  logic             dbz_d;

  // Magnitude of a two's-complement value when signed handling is enabled.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v,
                                               input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  // Re-apply a sign to a magnitude result (WIDTH-bit wrap is intended).
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign dbz  = dbz_q;

  // Opcode decode, one restoring-division step, and final result selection.
  always_comb begin
    op_ok  = (opcode == OP_DIVU) || (opcode == OP_MODU) ||
             (opcode == OP_DIVS) || (opcode == OP_MODS);
    op_sgn = (opcode == OP_DIVS) || (opcode == OP_MODS);
    op_mod = (opcode == OP_MODU) || (opcode == OP_MODS);

    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    qbit   = (rem_sh >= {1'b0, dvs_q});
    // The true difference is below the divisor, so low-WIDTH-bit math is exact.
    rem_d  = qbit ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], qbit};

    y_d   = '0;
    dbz_d = 1'b0;
    if (!unsup_q) begin
      if (zero_q) begin
        y_d   = is_mod_q ? aorig_q : '1;
        dbz_d = 1'b1;
      end else if (is_mod_q) begin
        y_d = apply_sign(rem_q, neg_rem_q);
      end else begin
        y_d = apply_sign(dvd_q, neg_quo_q);
      end
    end
  end

  // Control FSM with registered outputs: IDLE accepts, CALC iterates, FIX publishes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      aorig_q   <= '0;
      is_mod_q  <= 1'b0;
      unsup_q   <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_q       <= '0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            aorig_q   <= a;
            dvd_q     <= abs_mag(a, op_sgn);
            dvs_q     <= abs_mag(b, op_sgn);
            neg_quo_q <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= op_sgn & a[WIDTH-1];
            zero_q    <= (b == '0);
            is_mod_q  <= op_mod;
            unsup_q   <= !op_ok;
            rem_q     <= '0;
            count_q   <= CW'(WIDTH - 1);
            busy_q    <= 1'b1;
            state_q   <= op_ok ? CALC : FIX;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (count_q == '0) begin
            state_q <= FIX;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        FIX: begin
          y_q     <= y_d;
          dbz_q   <= dbz_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Testbench for alu_divider: vector table plus hand-written corner sequences,
// results checked through an expected-result queue popped on each done pulse.
module tb_alu_divider;

  localparam int W = 32;

  localparam logic [3:0] DIVU = 4'b1001;
  localparam logic [3:0] MODU = 4'b1010;
  localparam logic [3:0] DIVS = 4'b1011;
  localparam logic [3:0] MODS = 4'b1100;

  logic         clk;
  logic         nreset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         dbz;

  typedef struct packed {
    logic [W-1:0] y;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] y;
    logic         dbz;
    int           lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[16];
  int   total;
  int   bad;

  alu_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .start  (start),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .y      (y),
    .dbz    (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Result checker: every done pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=%h want=no_done", y);
      end else begin
        mon_e = sb.pop_front();
        chk("y", y, mon_e.y);
        chk("dbz", {31'd0, dbz}, {31'd0, mon_e.dbz});
      end
    end
  end

  // Issue one operation and check busy, latency, pulse width and hold of y.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [3:0] iop, input logic [W-1:0] ey,
                        input logic edbz, input int lat);
    int  n;
    bit  hit;
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; opcode = iop; start = 1'b1;
    e.y = ey; e.dbz = edbz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0; hit = 0;
    while (!hit && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) hit = 1;
      else if (busy !== 1'b1) begin
        total++; bad++;
        $display("FAIL busy_drop got=%b want=1 cycle=%0d", busy, n);
      end
    end
    chk("latency", n, lat);
    @(posedge clk);
    #1;
    chk("done_width", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("y_held", y, ey);
  endtask

  initial begin
    int   cyc;
    int   n;
    int   ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    exp_t e;

    vt[0]  = '{32'd100,        32'd7,          DIVU,    32'd14,         1'b0, 33};
    vt[1]  = '{32'd100,        32'd7,          MODU,    32'd2,          1'b0, 33};
    vt[2]  = '{32'hFFFFFF9C,   32'd7,          DIVS,    32'hFFFFFFF2,   1'b0, 33};
    vt[3]  = '{32'hFFFFFF9C,   32'd7,          MODS,    32'hFFFFFFFE,   1'b0, 33};
    vt[4]  = '{32'h12345678,   32'd0,          DIVU,    32'hFFFFFFFF,   1'b1, 33};
    vt[5]  = '{32'h80000005,   32'd0,          MODS,    32'h80000005,   1'b1, 33};
    vt[6]  = '{32'h80000000,   32'hFFFFFFFF,   DIVS,    32'h80000000,   1'b0, 33};
    vt[7]  = '{32'h80000000,   32'hFFFFFFFF,   MODS,    32'd0,          1'b0, 33};
    vt[8]  = '{32'hFFFFFF9C,   32'd0,          DIVS,    32'hFFFFFFFF,   1'b1, 33};
    vt[9]  = '{32'd55,         32'd3,          4'b1110, 32'd0,          1'b0, 1};
    vt[10] = '{32'h12345678,   32'd0,          MODU,    32'h12345678,   1'b1, 33};
    vt[11] = '{32'd100,        32'hFFFFFFF9,   DIVS,    32'hFFFFFFF2,   1'b0, 33};
    vt[12] = '{32'd100,        32'hFFFFFFF9,   MODS,    32'd2,          1'b0, 33};
    vt[13] = '{32'd7,          32'd100,        MODU,    32'd7,          1'b0, 33};
    vt[14] = '{32'hFFFFFFFF,   32'd1,          DIVU,    32'hFFFFFFFF,   1'b0, 33};
    vt[15] = '{32'd9,          32'd0,          4'b0000, 32'd0,          1'b0, 1};

    total = 0; bad = 0;
    nreset = 1'b0; start = 1'b0; a = '0; b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op(vt[i].a, vt[i].b, vt[i].op, vt[i].y, vt[i].dbz, vt[i].lat);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 5000);
      run_op(ra, rb, DIVU, ra / rb, 1'b0, 33);
      run_op(ra, rb, MODU, ra % rb, 1'b0, 33);
    end

    // DIVU 50/5 with a 9/3 start pulsed while busy: the second request is ignored.
    @(negedge clk);
    a = 32'd50; b = 32'd5; opcode = DIVU; start = 1'b1;
    e.y = 32'd10; e.dbz = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      start = (cyc == 9);
      if (cyc == 9) begin a = 32'd9; b = 32'd3; end
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (done === 1'b1) break;
    end
    chk("ignored_start_latency", cyc, 33);
    // Back-to-back: start raised in the done cycle is accepted.
    a = 32'd9; b = 32'd3; opcode = DIVU; start = 1'b1;
    e.y = 32'd3; e.dbz = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
    end
    chk("back_to_back_latency", n, 33);

    // Reset during an operation aborts it with no done pulse afterwards.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; opcode = DIVU; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_y", y, 32'd0);
    chk("abort_dbz", {31'd0, dbz}, 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    run_op(32'd200, 32'd9, DIVU, 32'd22, 1'b0, 33);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
